// File: rtl/eth_egress_reader_if.sv
// Output stream of the egress reader. The master drives the word and its flags,
// and the slave returns the accept.
interface eth_egress_reader_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_sop;
  logic                  m_eop;
  logic                  m_err;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output m_data, m_sop, m_eop, m_err, m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data, m_sop, m_eop, m_err, m_valid,
    output m_ready
  );
endinterface

// File: rtl/eth_egress_reader.sv
// Egress drain stage for one switch output port. It pops the switch FIFO under
// buffer credit, checks the packet framing, and streams the words out.
module eth_egress_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUF_DEPTH  = 4,
  parameter int unsigned MAX_LEN    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] outdata,
  input  logic                  outsop,
  input  logic                  outeop,
  input  logic                  stall_empty,
  output logic                  rd_en,
  eth_egress_reader_if.master   strm,
  output logic [15:0]           pkt_cnt,
  output logic [15:0]           err_cnt
);
  localparam int unsigned AW = $clog2(BUF_DEPTH);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   len, len_nxt;
  logic            inflight;
  logic            run;
  logic [AW:0]     wr_ptr, rd_ptr, count;
  logic [AW+1:0]   used;
  logic            buf_valid, pop;

  logic            wr, wr_sop, wr_eop, wr_err;
  logic            pkt_inc, err_inc;

  logic [DATA_WIDTH-1:0] mem_data  [BUF_DEPTH];
  logic [2:0]            mem_flags [BUF_DEPTH];
  logic [2:0]            head_flags;

  // Credit covers both buffered words and the word still on its way back.
  assign count     = wr_ptr - rd_ptr;
  assign used      = {1'b0, count} + (AW+2)'(inflight);
  assign buf_valid = (count != '0);
  assign pop       = buf_valid && strm.m_ready;

  // run keeps rd_en low while reset is asserted without a combinational reset path.
  assign rd_en = run && !stall_empty && (used < DEPTH_W);

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    wr        = 1'b0;
    wr_sop    = 1'b0;
    wr_eop    = 1'b0;
    wr_err    = 1'b0;
    pkt_inc   = 1'b0;
    err_inc   = 1'b0;
    if (inflight) begin
      // A SOP word opens a new packet from any state; mid-packet it is flagged.
      if (outsop) begin
        wr      = 1'b1;
        wr_sop  = 1'b1;
        wr_eop  = outeop;
        wr_err  = (state == IN_PKT);
        err_inc = (state == IN_PKT);
        len_nxt = LW'(1);
        if (outeop) begin
          pkt_inc   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = IN_PKT;
        end
      end else begin
        case (state)
          IDLE: err_inc = 1'b1;
          IN_PKT: begin
            wr = 1'b1;
            if (outeop) begin
              wr_eop    = 1'b1;
              pkt_inc   = 1'b1;
              state_nxt = IDLE;
            end else if (len == LW'(MAX_LEN - 1)) begin
              wr_eop    = 1'b1;
              wr_err    = 1'b1;
              err_inc   = 1'b1;
              state_nxt = DROP;
            end else begin
              len_nxt = len + LW'(1);
            end
          end
          DROP: begin
            if (outeop) state_nxt = IDLE;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      len      <= '0;
      inflight <= 1'b0;
      run      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      len      <= len_nxt;
      inflight <= rd_en;
      run      <= 1'b1;
      if (wr)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (pkt_inc) pkt_cnt <= pkt_cnt + 16'd1;
      if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_data[wr_ptr[AW-1:0]]  <= outdata;
      mem_flags[wr_ptr[AW-1:0]] <= {wr_sop, wr_eop, wr_err};
    end
  end

  assign head_flags   = mem_flags[rd_ptr[AW-1:0]];
  assign strm.m_valid = buf_valid;
  assign strm.m_data  = buf_valid ? mem_data[rd_ptr[AW-1:0]] : '0;
  assign strm.m_sop   = buf_valid & head_flags[2];
  assign strm.m_eop   = buf_valid & head_flags[1];
  assign strm.m_err   = buf_valid & head_flags[0];
endmodule

// File: tb/tb_eth_egress_reader.sv
// Scoreboard bench for eth_egress_reader: a switch FIFO model feeds the DUT and
// a monitor compares every accepted stream word against the expected queue.
module tb_eth_egress_reader;
  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic        err;
  } word_t;

  logic        clk, rst, ready, stall, sel;
  logic [31:0] outdata;
  logic        outsop, outeop;
  logic        rd_en0, rd_en1;
  logic [15:0] pc0, ec0, pc1, ec1;

  logic        rd, mv, msop, meop, merr;
  logic [31:0] md;
  logic [15:0] pc, ec;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rd_pulses, rd_first, out_first, out_last, out_count;

  word_t swq[$];
  word_t sb[$];

  eth_egress_reader_if #(.DATA_WIDTH(32)) s0 ();
  eth_egress_reader_if #(.DATA_WIDTH(32)) s1 ();
  assign s0.m_ready = ready;
  assign s1.m_ready = ready;

  eth_egress_reader #(.DATA_WIDTH(32), .BUF_DEPTH(4), .MAX_LEN(64)) dut0 (
    .clk(clk), .rst(rst), .outdata(outdata), .outsop(outsop), .outeop(outeop),
    .stall_empty(stall | sel), .rd_en(rd_en0), .strm(s0), .pkt_cnt(pc0), .err_cnt(ec0)
  );

  eth_egress_reader #(.DATA_WIDTH(32), .BUF_DEPTH(4), .MAX_LEN(4)) dut1 (
    .clk(clk), .rst(rst), .outdata(outdata), .outsop(outsop), .outeop(outeop),
    .stall_empty(stall | !sel), .rd_en(rd_en1), .strm(s1), .pkt_cnt(pc1), .err_cnt(ec1)
  );

  assign rd   = sel ? rd_en1     : rd_en0;
  assign mv   = sel ? s1.m_valid : s0.m_valid;
  assign md   = sel ? s1.m_data  : s0.m_data;
  assign msop = sel ? s1.m_sop   : s0.m_sop;
  assign meop = sel ? s1.m_eop   : s0.m_eop;
  assign merr = sel ? s1.m_err   : s0.m_err;
  assign pc   = sel ? pc1 : pc0;
  assign ec   = sel ? ec1 : ec0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic word_t mk(input logic [31:0] d, input logic s, input logic e, input logic r);
    word_t w;
    w.data = d;
    w.sop  = s;
    w.eop  = e;
    w.err  = r;
    return w;
  endfunction

  // Queue one switch word; if it should reach the stream, queue its expected form.
  task automatic push(input logic [31:0] d, input logic s, input logic e,
                      input logic expect_out, input logic expect_err);
    swq.push_back(mk(d, s, e, 1'b0));
    if (expect_out) sb.push_back(mk(d, s, e, expect_err));
    stall = 1'b0;
  endtask

  task automatic clear_stats();
    rd_pulses = 0;
    rd_first  = -1;
    out_first = -1;
    out_last  = -1;
    out_count = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    swq.delete();
    sb.delete();
    stall = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    clear_stats();
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!(swq.size() == 0 && sb.size() == 0 && !mv) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_leftover"}, 64'(sb.size()), 64'd0);
    repeat (4) @(posedge clk);
    #2;
  endtask

  // Switch egress FIFO: a pop sampled in one cycle returns its word in the next.
  initial begin : switch_model
    logic  pop;
    word_t w;
    stall   = 1'b1;
    outdata = '0;
    outsop  = 1'b0;
    outeop  = 1'b0;
    forever begin
      @(negedge clk);
      pop = rd;
      if (pop) begin
        rd_pulses++;
        if (rd_first < 0) rd_first = cyc;
      end
      @(posedge clk); #1;
      if (pop && swq.size() > 0) begin
        w       = swq.pop_front();
        outdata = w.data;
        outsop  = w.sop;
        outeop  = w.eop;
      end else begin
        outdata = 32'hDEAD_BEEF;
        outsop  = 1'b0;
        outeop  = 1'b0;
      end
      stall = (swq.size() == 0);
    end
  end

  always @(negedge clk) begin
    word_t e;
    if (rst && mv && ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL stream_unexpected: got data=%h sop=%b eop=%b err=%b expected no word",
                 md, msop, meop, merr);
      end else begin
        e = sb.pop_front();
        if ({md, msop, meop, merr} !== {e.data, e.sop, e.eop, e.err}) begin
          failures++;
          $display("FAIL stream_word: got data=%h sop=%b eop=%b err=%b expected data=%h sop=%b eop=%b err=%b",
                   md, msop, meop, merr, e.data, e.sop, e.eop, e.err);
        end
      end
      if (out_first < 0) out_first = cyc;
      out_last = cyc;
      out_count++;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin : stimulus
    rst   = 1'b1;
    ready = 1'b0;
    sel   = 1'b0;
    clear_stats();
    #3 rst = 1'b0;
    #1;
    chk("reset_rd_en",   64'(rd),   64'd0);
    chk("reset_m_valid", 64'(mv),   64'd0);
    chk("reset_m_data",  64'(md),   64'd0);
    chk("reset_pkt_cnt", 64'(pc),   64'd0);
    chk("reset_err_cnt", 64'(ec),   64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    clear_stats();
    repeat (2) @(posedge clk);
    #2;

    // Single 3-word packet at full rate
    ready = 1'b1;
    push(32'hA0, 1'b1, 1'b0, 1'b1, 1'b0);
    push(32'hA1, 1'b0, 1'b0, 1'b1, 1'b0);
    push(32'hA2, 1'b0, 1'b1, 1'b1, 1'b0);
    drain("t1");
    chk("t1_rd_pulses", 64'(rd_pulses),            64'd3);
    chk("t1_latency",   64'(out_first - rd_first), 64'd2);
    chk("t1_span",      64'(out_last - out_first), 64'd2);
    chk("t1_pkt_cnt",   64'(pc), 64'd1);
    chk("t1_err_cnt",   64'(ec), 64'd0);

    // 10-word packet under backpressure
    do_reset();
    ready = 1'b0;
    for (int unsigned i = 0; i < 10; i++)
      push(32'hB0 + 32'(i), (i == 0), (i == 9), 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      if (mv) chk("t2_hold_data", 64'(md), 64'hB0);
    end
    chk("t2_rd_pulses", 64'(rd_pulses), 64'd4);
    chk("t2_valid_held", 64'(mv), 64'd1);
    @(posedge clk); #2;
    ready = 1'b1;
    drain("t2");
    chk("t2_out_count", 64'(out_count), 64'd10);
    chk("t2_pkt_cnt",   64'(pc), 64'd1);
    chk("t2_err_cnt",   64'(ec), 64'd0);

    // Headless word, then a single-word packet
    do_reset();
    ready = 1'b1;
    push(32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    push(32'h66, 1'b1, 1'b1, 1'b1, 1'b0);
    drain("t3");
    chk("t3_out_count", 64'(out_count), 64'd1);
    chk("t3_pkt_cnt",   64'(pc), 64'd1);
    chk("t3_err_cnt",   64'(ec), 64'd1);

    // Premature SOP restarts the packet and is flagged
    do_reset();
    push(32'hC0, 1'b1, 1'b0, 1'b1, 1'b0);
    push(32'hC1, 1'b0, 1'b0, 1'b1, 1'b0);
    push(32'hC2, 1'b1, 1'b0, 1'b1, 1'b1);
    push(32'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    push(32'hC4, 1'b0, 1'b1, 1'b1, 1'b0);
    drain("t4");
    chk("t4_pkt_cnt", 64'(pc), 64'd1);
    chk("t4_err_cnt", 64'(ec), 64'd1);

    // Over-length packet on the MAX_LEN=4 instance, then a good packet after the drop
    do_reset();
    sel = 1'b1;
    push(32'hD0, 1'b1, 1'b0, 1'b1, 1'b0);
    push(32'hD1, 1'b0, 1'b0, 1'b1, 1'b0);
    push(32'hD2, 1'b0, 1'b0, 1'b1, 1'b0);
    sb.push_back(mk(32'hD3, 1'b0, 1'b1, 1'b1));
    swq.push_back(mk(32'hD3, 1'b0, 1'b0, 1'b0));
    push(32'hD4, 1'b0, 1'b0, 1'b0, 1'b0);
    push(32'hD5, 1'b0, 1'b1, 1'b0, 1'b0);
    drain("t5");
    chk("t5_out_count", 64'(out_count), 64'd4);
    chk("t5_pkt_cnt",   64'(pc), 64'd0);
    chk("t5_err_cnt",   64'(ec), 64'd1);
    push(32'hE0, 1'b1, 1'b1, 1'b1, 1'b0);
    drain("t5b");
    chk("t5b_pkt_cnt", 64'(pc), 64'd1);
    chk("t5b_err_cnt", 64'(ec), 64'd1);

    // Reset with two words buffered and a read in flight
    do_reset();
    sel   = 1'b0;
    ready = 1'b0;
    for (int unsigned i = 0; i < 6; i++)
      push(32'hF0 + 32'(i), (i == 0), (i == 5), 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    chk("t6_pre_rd_en",   64'(rd), 64'd1);
    chk("t6_pre_m_valid", 64'(mv), 64'd1);
    rst = 1'b0;
    #1;
    chk("t6_rst_rd_en",   64'(rd),   64'd0);
    chk("t6_rst_m_valid", 64'(mv),   64'd0);
    chk("t6_rst_m_data",  64'(md),   64'd0);
    chk("t6_rst_m_sop",   64'(msop), 64'd0);
    chk("t6_rst_m_eop",   64'(meop), 64'd0);
    chk("t6_rst_m_err",   64'(merr), 64'd0);
    swq.delete();
    sb.delete();
    stall = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    clear_stats();
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    push(32'h70, 1'b1, 1'b0, 1'b1, 1'b0);
    push(32'h71, 1'b0, 1'b1, 1'b1, 1'b0);
    drain("t6");
    chk("t6_out_count", 64'(out_count), 64'd2);
    chk("t6_pkt_cnt",   64'(pc), 64'd1);
    chk("t6_err_cnt",   64'(ec), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eth_egress_reader.md
# eth_egress_reader

Egress drain stage placed directly downstream of one output port of the 2x2 switch (one instance per port). It issues `rd_en` to the switch's egress FIFO while that FIFO is non-empty and local buffer credit allows. It captures the returned word with its SOP/EOP flags and checks packet framing. Checked words are forwarded on a valid/ready stream to the MAC/scoreboard side, together with packet and error counters.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of switch output data and stream data.
- `BUF_DEPTH`, 4: output buffer entries; power of two, ≥2.
- `MAX_LEN`, 64: maximum words per packet, SOP and EOP words included.

Ports:
- `clk`, in, 1: sole clock; all logic on the rising edge.
- `rst`, in, 1: reset, asynchronous assert, active-low; release is synchronised externally.
- `outdata`, in, DATA_WIDTH: switch egress data, valid the cycle after `rd_en`.
- `outsop`, in, 1: SOP flag accompanying `outdata`.
- `outeop`, in, 1: EOP flag accompanying `outdata`.
- `stall_empty`, in, 1: switch egress FIFO empty.
- `rd_en`, out, 1: pop request to the switch egress FIFO.
- `m_data`, out, DATA_WIDTH: stream data.
- `m_sop`, out, 1: stream SOP.
- `m_eop`, out, 1: stream EOP.
- `m_err`, out, 1: word belongs to a malformed or truncated packet.
- `m_valid`, out, 1: stream word valid.
- `m_ready`, in, 1: downstream accept.
- `pkt_cnt`, out, 16: packets completed with a good EOP; wraps.
- `err_cnt`, out, 16: framing events; saturates at 0xFFFF.

## Operation
Read control:
- `rd_en` = `!stall_empty && (occupancy + inflight) < BUF_DEPTH`.
- `inflight` is 1 in the cycle after `rd_en` was high, otherwise 0.
- `rd_en` is combinational from registered state and `stall_empty`.

Capture:
- When `inflight` = 1, {`outdata`, `outsop`, `outeop`} is sampled and passed to the framer.
- The framer writes zero or one word into the buffer per cycle.

Framer FSM:
- IDLE
  - SOP word: write the word, `len` = 1. Go to IN_PKT, or stay in IDLE if EOP is also set (single-word packet, `pkt_cnt`+1).
  - Word without SOP: discard, `err_cnt`+1, stay in IDLE.
- IN_PKT
  - Plain word: write, `len`+1.
  - EOP word: write, `pkt_cnt`+1, go to IDLE.
  - SOP word (premature): write with `m_err`=1 as the first word of a new packet, `err_cnt`+1, `len` = 1. The previous packet is left without EOP.
  - Word that would make `len` = MAX_LEN without EOP: write with `m_eop`=1, `m_err`=1, `err_cnt`+1, go to DROP.
- DROP
  - Discard all words.
  - On EOP: go to IDLE.
  - On SOP: handle as in IDLE.

Buffer:
- BUF_DEPTH-entry FIFO of {data, sop, eop, err}.
- Simultaneous write and read permitted at any occupancy, including full and empty.
- No write can overflow the buffer, because read credit is checked before each read is issued.

Stream:
- `m_valid` = buffer non-empty; head word is driven.
- Pop when `m_valid && m_ready`.
- Data is held stable while `m_valid && !m_ready`.

Counters:
- `pkt_cnt` wraps 0xFFFF → 0.
- `err_cnt` holds at 0xFFFF.

## Timing
- Reset (async, `rst`=0): `rd_en`=0, `m_valid`=0, `m_data`/`m_sop`/`m_eop`/`m_err`=0, counters=0, FSM=IDLE, buffer empty, `inflight`=0.
- Latency: `rd_en` high in cycle N → word captured at end of N+1 → `m_valid` high in N+2 (buffer previously empty).
- Throughput: one word per cycle sustained when `m_ready`=1.
- Backpressure: with `m_ready`=0, `rd_en` deasserts as soon as occupancy + inflight = BUF_DEPTH; at most BUF_DEPTH words accepted.
- Reset mid-packet: buffer and in-flight word are lost; the next packet is framed from IDLE.

## Test plan
- Single 3-word packet (0xA0 SOP, 0xA1, 0xA2 EOP), `m_ready`=1 → `rd_en` in cycles 0–2; stream words in cycles 2–4 with `m_sop` on 0xA0 and `m_eop` on 0xA2; `pkt_cnt`=1, `err_cnt`=0.
- 10-word packet, `m_ready`=0 for 20 cycles → exactly 4 `rd_en` pulses, then stall; `m_data` held at word 0; after `m_ready`=1 all 10 words arrive in order.
- Headless word 0x55 (no SOP) then a good 1-word packet (SOP+EOP, 0x66) → 0x55 never appears on the stream; 0x66 with `m_sop`=`m_eop`=1; `err_cnt`=1, `pkt_cnt`=1.
- SOP, word, then SOP again, word, EOP → second SOP word carries `m_err`=1; `err_cnt`=1, `pkt_cnt`=1.
- MAX_LEN=4, 6-word packet → 4 words out, 4th with `m_eop`=`m_err`=1; words 5–6 dropped; `err_cnt`=1, `pkt_cnt`=0.
- `rst` low while 2 words are buffered and `rd_en`=1 → all outputs 0 in the same cycle; after release, the next good packet yields `pkt_cnt`=1.
